// File: rtl/flagged_packet_reader.sv
// flagged_packet_reader
// Replays length-prefixed packets from the sniffer capture RAM as a 32-bit
// Avalon-ST source stream (data/sop/eop/empty/valid with ready backpressure).
// Each packet in memory is one header word (byte length in [15:0]) followed
// by ceil(L/4) big-endian data words. Returned RAM words are tagged and
// pass through a 2-entry skid FIFO that drives the stream outputs.
//
// Optional feature macro: PKT_COUNT_EN
//   defined   -> 16-bit pkt_count of completed packets (clears on start)
//   undefined -> pkt_count tied to 0

module flagged_packet_reader #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       data_out,
    output logic              sop,
    output logic              eop,
    output logic [1:0]        empty,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic [15:0]       pkt_count
);

    typedef enum logic [2:0] {
        StIdle,
        StHdrReq,
        StHdrWait,
        StData,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [14:0]       cnt_q, cnt_d;
    logic [1:0]        len_lo_q, len_lo_d;
    logic              first_q, first_d;
    logic              len_err_q, len_err_d;

    // Tags for the data read currently in flight (returns next cycle).
    logic              pend_q;
    logic              pend_sop_q, pend_eop_q;
    logic [1:0]        pend_empty_q;

    // Skid FIFO: {data[31:0], sop, eop, empty[1:0]}.
    logic [35:0]       fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;

    logic              issue;
    logic              tag_sop, tag_eop;
    logic [1:0]        tag_empty;
    logic              clr_cnt;
    logic              push, pop;
    logic [2:0]        occ;
    logic              room;
    logic              path_empty;

    logic [15:0]       hdr_len;
    logic [16:0]       len_plus;
    logic [14:0]       hdr_words;
    logic              len_ok;
    logic              unused_len_lsb;

    logic [31:0]       head_data;
    logic              head_sop, head_eop;
    logic [1:0]        head_empty;

    // Header decode: byte length, word count and legality.
    assign hdr_len        = rd_data[15:0];
    assign len_plus       = {1'b0, hdr_len} + 17'd3;
    assign hdr_words      = len_plus[16:2];
    assign len_ok         = (hdr_len != 16'd0) && (32'(hdr_len) <= MAX_LEN);
    assign unused_len_lsb = ^len_plus[1:0];

    // Stream handshake and read-issue budget.
    assign valid      = (count_q != 2'd0);
    assign pop        = valid && ready;
    assign push       = pend_q;
    assign occ        = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
    assign room       = (occ < 3'd2);
    assign path_empty = (count_q == 2'd0) && !pend_q;

    assign {head_data, head_sop, head_eop, head_empty} = fifo_q[rd_ptr_q];
    assign data_out = head_data;
    assign sop      = valid && head_sop;
    assign eop      = valid && head_eop;
    assign empty    = valid ? head_empty : 2'd0;

    assign rd_addr = ptr_q;
    assign busy    = (state_q != StIdle);
    assign len_err = len_err_q;

    // Next-state, read issue and tagging.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        end_d     = end_q;
        cnt_d     = cnt_q;
        len_lo_d  = len_lo_q;
        first_d   = first_q;
        len_err_d = len_err_q;
        rd_en     = 1'b0;
        issue     = 1'b0;
        tag_sop   = 1'b0;
        tag_eop   = 1'b0;
        tag_empty = 2'd0;
        clr_cnt   = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d     = start_addr;
                    end_d     = end_addr;
                    len_err_d = 1'b0;
                    clr_cnt   = 1'b1;
                    state_d   = StHdrReq;
                end
            end

            StHdrReq: begin
                if (ptr_q == end_q) begin
                    state_d = StDrain;
                end else begin
                    rd_en   = 1'b1;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = StHdrWait;
                end
            end

            StHdrWait: begin
                if (!len_ok) begin
                    len_err_d = 1'b1;
                    state_d   = StDrain;
                end else begin
                    len_lo_d = hdr_len[1:0];
                    // Fast-start the first data read only when nothing is queued
                    // ahead of it; otherwise DATA issues it under the room rule.
                    if (path_empty) begin
                        rd_en     = 1'b1;
                        issue     = 1'b1;
                        ptr_d     = ptr_q + ADDR_W'(1);
                        tag_sop   = 1'b1;
                        tag_eop   = (hdr_words == 15'd1);
                        tag_empty = tag_eop ? (2'd0 - hdr_len[1:0]) : 2'd0;
                        cnt_d     = hdr_words - 15'd1;
                        first_d   = 1'b0;
                        state_d   = (hdr_words == 15'd1) ? StHdrReq : StData;
                    end else begin
                        cnt_d   = hdr_words;
                        first_d = 1'b1;
                        state_d = StData;
                    end
                end
            end

            StData: begin
                if (room) begin
                    rd_en     = 1'b1;
                    issue     = 1'b1;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    tag_sop   = first_q;
                    tag_eop   = (cnt_q == 15'd1);
                    tag_empty = tag_eop ? (2'd0 - len_lo_q) : 2'd0;
                    cnt_d     = cnt_q - 15'd1;
                    first_d   = 1'b0;
                    if (cnt_q == 15'd1) begin
                        state_d = StHdrReq;
                    end
                end
            end

            StDrain: begin
                if (path_empty) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            end_q     <= '0;
            cnt_q     <= '0;
            len_lo_q  <= 2'd0;
            first_q   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            end_q     <= end_d;
            cnt_q     <= cnt_d;
            len_lo_q  <= len_lo_d;
            first_q   <= first_d;
            len_err_q <= len_err_d;
        end
    end

    // In-flight data read and its tags, aligned with rd_data next cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend_q       <= 1'b0;
            pend_sop_q   <= 1'b0;
            pend_eop_q   <= 1'b0;
            pend_empty_q <= 2'd0;
        end else begin
            pend_q <= issue;
            if (issue) begin
                pend_sop_q   <= tag_sop;
                pend_eop_q   <= tag_eop;
                pend_empty_q <= tag_empty;
            end
        end
    end

    // Two-entry skid FIFO; the head entry holds still while stalled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {rd_data, pend_sop_q, pend_eop_q, pend_empty_q};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef PKT_COUNT_EN
    logic [15:0] pkt_count_q;

    // Completed-packet counter: one per eop transfer, wraps naturally.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_count_q <= 16'd0;
        end else if (clr_cnt) begin
            pkt_count_q <= 16'd0;
        end else if (pop && eop) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign pkt_count      = 16'd0;
`endif

endmodule

// File: tb/tb_flagged_packet_reader.sv
// Self-checking bench for flagged_packet_reader: a RAM model with 1-cycle
// read latency, a scoreboard of expected stream words filled when packets are
// written to memory, and a negedge monitor that pops/compares on transfers.

module tb_flagged_packet_reader;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = 16'd0;
    logic [15:0] end_addr = 16'd0;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [31:0] rd_data = 32'd0;
    logic [31:0] data_out;
    logic        sop, eop;
    logic [1:0]  empty;
    logic        valid;
    logic        ready = 1'b1;
    logic        busy, done, len_err;
    logic [15:0] pkt_count;

`ifdef PKT_COUNT_EN
    localparam bit CntOn = 1'b1;
`else
    localparam bit CntOn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic [1:0]  em;
    } word_t;

    logic [31:0] mem [0:65535];
    word_t       exp_q[$];
    logic [15:0] rd_log[$];
    int          rd_cyc[$];
    int          sop_cyc[$];
    int          eop_cyc[$];
    int          n_cmp = 0, n_fail = 0;
    int          cyc = 0, e0 = 0, cn = 0;
    int          done_cnt, done_cyc, valid_cnt, xfer_cnt, first_xfer, last_xfer;
    bit          rand_ready = 1'b0;
    bit          stall_prev = 1'b0;
    word_t       held, got, expw;
    logic [72:0] snap;

    flagged_packet_reader dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .data_out   (data_out),
        .sop        (sop),
        .eop        (eop),
        .empty      (empty),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .len_err    (len_err),
        .pkt_count  (pkt_count)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM model: data valid the cycle after rd_en.
    initial forever begin
        @(posedge clk);
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Ready driver: held high, or 50% random while rand_ready is set.
    initial forever begin
        @(posedge clk);
        #1;
        ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Stream monitor and scoreboard.
    initial forever begin
        @(negedge clk);
        if (!n_rst) begin
            stall_prev = 1'b0;
        end else begin
            cn = cyc - e0 + 1;
            if (rd_en) begin
                rd_log.push_back(rd_addr);
                rd_cyc.push_back(cn);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cn;
            end
            if (valid) valid_cnt++;
            got = {data_out, sop, eop, empty};
            if (stall_prev) begin
                n_cmp++;
                if ({valid, got} !== {1'b1, held}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%b word=%h, held word=%h", valid, got,
                             held);
                end
            end
            if (valid && ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got word %h, expected no word", got);
                end else begin
                    expw = exp_q.pop_front();
                    if (got !== expw) begin
                        n_fail++;
                        $display("FAIL stream_word: got %h expected %h", got, expw);
                    end
                end
                if (first_xfer < 0) first_xfer = cn;
                last_xfer = cn;
                xfer_cnt++;
                if (sop) sop_cyc.push_back(cn);
                if (eop) eop_cyc.push_back(cn);
            end
            stall_prev = valid && !ready;
            held = got;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_stats();
        rd_log.delete();
        rd_cyc.delete();
        sop_cyc.delete();
        eop_cyc.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        valid_cnt  = 0;
        xfer_cnt   = 0;
        first_xfer = -1;
        last_xfer  = -1;
    endtask

    // Write one packet; legal packets also push their expected stream words.
    task automatic load_pkt(input logic [15:0] addr, input int len, output logic [15:0] nxt);
        int          w;
        logic [31:0] d;
        logic [15:0] a;
        word_t       x;
        mem[addr] = {16'($urandom), 16'(len)};
        if (len > 0 && len <= 1518) begin
            w = (len + 3) / 4;
            for (int i = 0; i < w; i++) begin
                a      = addr + 16'(i + 1);
                d      = $urandom;
                mem[a] = d;
                x.d    = d;
                x.s    = (i == 0);
                x.e    = (i == w - 1);
                x.em   = (i == w - 1) ? 2'(4 * w - len) : 2'd0;
                exp_q.push_back(x);
            end
            nxt = addr + 16'(w + 1);
        end else begin
            nxt = addr + 16'd1;
        end
    endtask

    // Pulse start; e0 is the cycle count just after the sampling edge.
    task automatic do_start(input logic [15:0] sa, input logic [15:0] ea);
        @(posedge clk);
        #1;
        clear_stats();
        start      = 1'b1;
        start_addr = sa;
        end_addr   = ea;
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        #12;
        snap = {rd_en, rd_addr, data_out, sop, eop, empty, valid, busy, done, len_err, pkt_count};
        n_cmp++;
        if (snap !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_in: got %h expected 0", snap);
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        snap = {rd_en, rd_addr, data_out, sop, eop, empty, valid, busy, done, len_err, pkt_count};
        n_cmp++;
        if (snap !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected 0", snap);
        end
    endtask

    task automatic test_single();
        logic [15:0] nx;
        exp_q.delete();
        load_pkt(16'h0010, 60, nx);
        do_start(16'h0010, 16'h0020);
        wait_done(100, "single");
        n_cmp++;
        if ({rd_cyc[0], rd_cyc[1], rd_log[0], rd_log[1]} !== {32'd1, 32'd2, 16'h0010, 16'h0011})
        begin
            n_fail++;
            $display("FAIL single_rd_timing: got cyc %0d,%0d addr %h,%h expected 1,2 0010,0011",
                     rd_cyc[0], rd_cyc[1], rd_log[0], rd_log[1]);
        end
        n_cmp++;
        if (first_xfer !== 4) begin
            n_fail++;
            $display("FAIL single_first_valid: got cycle %0d expected 4", first_xfer);
        end
        n_cmp++;
        if ({xfer_cnt, last_xfer - first_xfer} !== {32'd15, 32'd14}) begin
            n_fail++;
            $display("FAIL single_burst: got %0d words over %0d cycles expected 15 over 14",
                     xfer_cnt, last_xfer - first_xfer);
        end
        n_cmp++;
        if ({done_cnt, done_cyc} !== {32'd1, last_xfer + 1}) begin
            n_fail++;
            $display("FAIL single_done: got %0d pulses at %0d expected 1 at %0d", done_cnt,
                     done_cyc, last_xfer + 1);
        end
        n_cmp++;
        if ({pkt_count, busy, len_err, 32'(exp_q.size())} !== {16'(CntOn), 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL single_end: got cnt=%0d busy=%b err=%b left=%0d expected %0d,0,0,0",
                     pkt_count, busy, len_err, exp_q.size(), CntOn);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] nx, nx2;
        exp_q.delete();
        load_pkt(16'h0100, 61, nx);
        load_pkt(nx, 64, nx2);
        do_start(16'h0100, nx2);
        wait_done(200, "b2b");
        n_cmp++;
        if ({xfer_cnt, 32'(exp_q.size())} !== {32'd32, 32'd0}) begin
            n_fail++;
            $display("FAIL b2b_words: got %0d words, %0d left expected 32, 0", xfer_cnt,
                     exp_q.size());
        end
        n_cmp++;
        if (sop_cyc[1] - eop_cyc[0] - 1 !== 2) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d idle cycles expected 2", sop_cyc[1] - eop_cyc[0] - 1);
        end
        n_cmp++;
        if (pkt_count !== 16'(CntOn ? 2 : 0)) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected %0d", pkt_count, CntOn ? 2 : 0);
        end
    endtask

    task automatic test_random_ready();
        logic [15:0] nx;
        exp_q.delete();
        load_pkt(16'h0500, 61, nx);
        rand_ready = 1'b1;
        do_start(16'h0500, nx);
        wait_done(600, "random");
        rand_ready = 1'b0;
        n_cmp++;
        if ({xfer_cnt, done_cnt, 32'(exp_q.size())} !== {32'd16, 32'd1, 32'd0}) begin
            n_fail++;
            $display("FAIL random_words: got %0d words, %0d done, %0d left expected 16, 1, 0",
                     xfer_cnt, done_cnt, exp_q.size());
        end
    endtask

    task automatic test_len_err();
        logic [15:0] nx;
        int          lens[2];
        lens[0] = 0;
        lens[1] = 1519;
        for (int k = 0; k < 2; k++) begin
            exp_q.delete();
            load_pkt(16'h0300, lens[k], nx);
            do_start(16'h0300, 16'h0301);
            @(negedge clk);
            n_cmp++;
            if (len_err !== 1'b0) begin
                n_fail++;
                $display("FAIL lenerr_clear_%0d: got %b expected 0", lens[k], len_err);
            end
            wait_done(50, "lenerr");
            n_cmp++;
            if ({done_cyc, valid_cnt, len_err} !== {32'd3, 32'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL lenerr_abort_%0d: got done@%0d valid=%0d err=%b expected 3,0,1",
                         lens[k], done_cyc, valid_cnt, len_err);
            end
            repeat (5) @(negedge clk);
            n_cmp++;
            if ({len_err, done_cnt} !== {1'b1, 32'd1}) begin
                n_fail++;
                $display("FAIL lenerr_hold_%0d: got err=%b done=%0d expected 1,1", lens[k],
                         len_err, done_cnt);
            end
        end
        // Largest legal length streams in full with empty = 2.
        exp_q.delete();
        load_pkt(16'h0600, 1518, nx);
        do_start(16'h0600, nx);
        @(negedge clk);
        n_cmp++;
        if (len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL maxlen_clear: got %b expected 0", len_err);
        end
        wait_done(1000, "maxlen");
        n_cmp++;
        if ({xfer_cnt, 32'(exp_q.size()), len_err} !== {32'd380, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL maxlen_words: got %0d words, %0d left, err=%b expected 380,0,0",
                     xfer_cnt, exp_q.size(), len_err);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] nx;
        exp_q.delete();
        do_start(16'hFFFF, 16'hFFFF);
        wait_done(20, "wrap_empty");
        n_cmp++;
        if ({32'(rd_log.size()), done_cyc, valid_cnt} !== {32'd0, 32'd2, 32'd0}) begin
            n_fail++;
            $display("FAIL wrap_empty: got %0d reads, done@%0d, valid=%0d expected 0,2,0",
                     rd_log.size(), done_cyc, valid_cnt);
        end
        load_pkt(16'hFFFE, 8, nx);
        do_start(16'hFFFE, nx);
        wait_done(50, "wrap_pkt");
        n_cmp++;
        if ({32'(rd_log.size()), rd_log[0], rd_log[1], rd_log[2]} !==
            {32'd3, 16'hFFFE, 16'hFFFF, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_addr: got %0d reads %h %h %h expected 3 FFFE FFFF 0000",
                     rd_log.size(), rd_log[0], rd_log[1], rd_log[2]);
        end
        n_cmp++;
        if ({xfer_cnt, 32'(exp_q.size())} !== {32'd2, 32'd0}) begin
            n_fail++;
            $display("FAIL wrap_words: got %0d words, %0d left expected 2, 0", xfer_cnt,
                     exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] nx;
        int          guard;
        exp_q.delete();
        load_pkt(16'h0200, 400, nx);
        do_start(16'h0200, nx);
        guard = 0;
        while (xfer_cnt < 10 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        #2;
        n_rst = 1'b0;
        #1;
        snap = {rd_en, rd_addr, data_out, sop, eop, empty, valid, busy, done, len_err, pkt_count};
        n_cmp++;
        if (snap !== 73'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected 0 (after %0d words)", snap, xfer_cnt);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        load_pkt(16'h0400, 20, nx);
        do_start(16'h0400, nx);
        wait_done(100, "reset_replay");
        n_cmp++;
        if ({first_xfer, xfer_cnt, 32'(exp_q.size()), pkt_count} !==
            {32'd4, 32'd5, 32'd0, 16'(CntOn)}) begin
            n_fail++;
            $display("FAIL reset_replay: got first@%0d words=%0d left=%0d cnt=%0d exp 4,5,0,%0d",
                     first_xfer, xfer_cnt, exp_q.size(), pkt_count, CntOn);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        clear_stats();
        test_reset();
        test_single();
        test_back_to_back();
        test_random_ready();
        test_len_err();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
